// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an async FIFO: read pointer, empty detect, RAM read issue, 2-entry output buffer.
// Latency: ren in cycle N gives m_valid in cycle N+2; streams one word per cycle in steady state.
// Backpressure: a read is issued only while the buffer has a free slot; m_valid/m_data hold while m_valid && !m_ready.
//
// Ports:
//   rclk, srst      read-domain clock; synchronous active-high reset
//   wptr_gray_sync  write pointer (Gray), already synchronised into rclk
//   rptr_gray       registered read pointer (Gray) for the write-domain synchroniser
//   ren, raddr      RAM read request
//   rdv, rdata      RAM registered read response (one cycle after ren)
//   m_valid, m_data, m_ready   output valid/ready stream
//   empty           !m_valid
//   rd_level        words not yet popped, registered (present only with FIFO_RD_LEVEL_EN)
//
// Optional feature macro: FIFO_RD_LEVEL_EN (adds the rd_level port and its logic).

module fifo_rd_ctrl #(
   parameter int AWIDTH = 9,
   parameter int DWIDTH = 16
) (
   input  logic              rclk,
   input  logic              srst,
   input  logic [AWIDTH:0]   wptr_gray_sync,
   output logic [AWIDTH:0]   rptr_gray,
   output logic              ren,
   output logic [AWIDTH-1:0] raddr,
   input  logic              rdv,
   input  logic [DWIDTH-1:0] rdata,
   output logic              m_valid,
   output logic [DWIDTH-1:0] m_data,
   input  logic              m_ready,
   output logic              empty
`ifdef FIFO_RD_LEVEL_EN
   ,
   output logic [AWIDTH:0]   rd_level
`endif
);

   localparam int PW = AWIDTH + 1;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [AWIDTH:0]   rptr_bin_q,  rptr_bin_d;
   logic [AWIDTH:0]   rptr_gray_q, rptr_gray_d;
   logic              inflight_q,  inflight_d;
   logic [1:0]        occ_q,       occ_d;
   logic [DWIDTH-1:0] buf0_q,      buf0_d;     // head of the output buffer
   logic [DWIDTH-1:0] buf1_q,      buf1_d;     // second entry

   // ------------------------------------------------------------------
   // Read issue
   // ------------------------------------------------------------------
   logic       mem_empty;
   logic       pop;
   logic       cap;
   logic [2:0] credit_used;

   assign mem_empty = (wptr_gray_sync == rptr_gray_q);
   assign m_valid   = (occ_q != 2'd0);
   assign pop       = m_valid && m_ready;

   // A returning word is only accepted if we actually asked for it, so a
   // response that straddles a reset is dropped.
   assign cap = rdv && inflight_q;

   // Slots already spoken for (buffered + on the way from the RAM), minus the
   // one leaving this cycle. Using pop here is what allows back-to-back reads
   // at full rate; it puts m_ready on a combinational path to ren.
   assign credit_used = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

   assign ren   = !srst && !mem_empty && (credit_used < 3'd2);
   assign raddr = rptr_bin_q[AWIDTH-1:0];

   assign rptr_gray = rptr_gray_q;
   assign m_data    = buf0_q;
   assign empty     = !m_valid;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      rptr_bin_d  = rptr_bin_q;
      rptr_gray_d = rptr_gray_q;
      inflight_d  = ren;
      occ_d       = occ_q;
      buf0_d      = buf0_q;
      buf1_d      = buf1_q;

      if (ren) begin
         rptr_bin_d  = rptr_bin_q + PW'(1);
         rptr_gray_d = rptr_bin_d ^ (rptr_bin_d >> 1);
      end

      // Two-entry in-order buffer: buf0 is always the head.
      unique case ({cap, pop})
         2'b01: begin
            buf0_d = buf1_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b10: begin
            if (occ_q == 2'd0) begin
               buf0_d = rdata;
            end else begin
               buf1_d = rdata;
            end
            occ_d = occ_q + 2'd1;
         end
         2'b11: begin
            // Head leaves while a new word arrives; occupancy unchanged.
            if (occ_q == 2'd1) begin
               buf0_d = rdata;
            end else begin
               buf0_d = buf1_q;
               buf1_d = rdata;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge rclk) begin
      if (srst) begin
         rptr_bin_q  <= '0;
         rptr_gray_q <= '0;
         inflight_q  <= 1'b0;
         occ_q       <= 2'd0;
         buf0_q      <= '0;
         buf1_q      <= '0;
      end else begin
         rptr_bin_q  <= rptr_bin_d;
         rptr_gray_q <= rptr_gray_d;
         inflight_q  <= inflight_d;
         occ_q       <= occ_d;
         buf0_q      <= buf0_d;
         buf1_q      <= buf1_d;
      end
   end

   // ------------------------------------------------------------------
   // Optional fill level
   // ------------------------------------------------------------------
`ifdef FIFO_RD_LEVEL_EN
   function automatic logic [AWIDTH:0] gray2bin(input logic [AWIDTH:0] g);
      logic [AWIDTH:0] b;
      b[AWIDTH] = g[AWIDTH];
      for (int i = AWIDTH - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [AWIDTH:0] rd_level_q, rd_level_d;

   // Words in the RAM not yet read, plus the one in flight, plus those
   // buffered. The write pointer lags, so this never over-reports.
   always_comb begin
      rd_level_d = (gray2bin(wptr_gray_sync) - rptr_bin_q)
                 + PW'(inflight_q)
                 + PW'(occ_q);
   end

   always_ff @(posedge rclk) begin
      if (srst) begin
         rd_level_q <= '0;
      end else begin
         rd_level_q <= rd_level_d;
      end
   end

   assign rd_level = rd_level_q;
`endif

   // ------------------------------------------------------------------
   // Simulation-only protocol checks
   // ------------------------------------------------------------------
`ifndef SYNTHESIS
   // The RAM answers every ren exactly one cycle later. The first cycle out
   // of reset is exempt: a read launched just before reset may land there.
   a_rdv_tracks_inflight: assert property (
      @(posedge rclk) disable iff (srst) !$past(srst) |-> (rdv == inflight_q));

   a_credit_bound: assert property (
      @(posedge rclk) disable iff (srst) (({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd2));
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: directed scenarios plus randomized traffic checked against a counter/queue model.
// Latency: model expects m_valid two cycles after each read issue.
// Backpressure: random m_ready; head word compared every valid cycle.

module tb_fifo_rd_ctrl;

   localparam int AW    = 2;
   localparam int DW    = 16;
   localparam int DEPTH = 1 << AW;
   localparam int PMOD  = 1 << (AW + 1);

   logic          clk = 1'b0;
   logic          srst = 1'b1;
   logic [AW:0]   wptr_gray_sync = '0;
   logic [AW:0]   rptr_gray;
   logic          ren;
   logic [AW-1:0] raddr;
   logic          rdv = 1'b0;
   logic [DW-1:0] rdata = '0;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_ready = 1'b0;
   logic          empty;
`ifdef FIFO_RD_LEVEL_EN
   logic [AW:0]   rd_level;
`endif

   always #5 clk = ~clk;

   fifo_rd_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) u_dut (
      .rclk           (clk),
      .srst           (srst),
      .wptr_gray_sync (wptr_gray_sync),
      .rptr_gray      (rptr_gray),
      .ren            (ren),
      .raddr          (raddr),
      .rdv            (rdv),
      .rdata          (rdata),
      .m_valid        (m_valid),
      .m_data         (m_data),
      .m_ready        (m_ready),
      .empty          (empty)
`ifdef FIFO_RD_LEVEL_EN
      ,
      .rd_level       (rd_level)
`endif
   );

   // RAM model: registered read, rdv = ren delayed. inj_rdv forces a stray response.
   logic [DW-1:0] mem [DEPTH];
   logic          inj_rdv = 1'b0;

   always @(posedge clk) begin
      rdv   <= ren | inj_rdv;
      rdata <= inj_rdv ? 16'hDEAD : mem[raddr];
   end

   // ------------------------------------------------------------------
   // Reference model: plain counts of words written, read and popped.
   // ------------------------------------------------------------------
   int            n_chk  = 0;
   int            n_fail = 0;
   int            wcnt = 0;        // words made visible through wptr_gray_sync
   int            reads = 0;       // read requests issued since reset
   int            reads_prev = 0;  // reads issued before the previous cycle
   int            pops = 0;        // words accepted downstream since reset
   int            lvl_exp = 0;
   logic [DW-1:0] exp_q [$];       // written, not yet popped, in order

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [AW:0] gray(input int b);
      int m;
      m = b % PMOD;
      return (AW+1)'(m ^ (m >> 1));
   endfunction

   task automatic write_word(input logic [DW-1:0] d);
      mem[wcnt % DEPTH] = d;
      exp_q.push_back(d);
      wcnt++;
   endtask

   task automatic env_clear();
      wcnt = 0;
      exp_q.delete();
   endtask

   // One clock cycle: drive inputs, check every output against the model,
   // then advance the model for the coming edge.
   task automatic cycle(input bit rst, input bit rdy, output bit o_ren, output bit o_vld);
      bit exp_valid, exp_pop, exp_ren;
      @(negedge clk);
      srst           = rst;
      m_ready        = rdy;
      wptr_gray_sync = gray(wcnt);
      #1;
      exp_valid = (reads_prev - pops) > 0;
      exp_pop   = exp_valid && rdy && !rst;
      exp_ren   = !rst && (wcnt > reads) && ((reads - pops - int'(exp_pop)) < 2);
      chk("m_valid",   32'(m_valid),   32'(exp_valid));
      chk("empty",     32'(empty),     32'(!exp_valid));
      chk("ren",       32'(ren),       32'(exp_ren));
      chk("raddr",     32'(raddr),     32'(reads % DEPTH));
      chk("rptr_gray", 32'(rptr_gray), 32'(gray(reads)));
      if (exp_valid) chk("m_data", 32'(m_data), 32'(exp_q[0]));
`ifdef FIFO_RD_LEVEL_EN
      chk("rd_level", 32'(rd_level), 32'(lvl_exp % PMOD));
      lvl_exp = rst ? 0 : (wcnt - pops);
`endif
      o_ren = ren;
      o_vld = m_valid;
      if (rst) begin
         reads = 0; reads_prev = 0; pops = 0;
      end else begin
         if (exp_pop) begin
            void'(exp_q.pop_front());
            pops++;
         end
         reads_prev = reads;
         if (exp_ren) reads++;
      end
   endtask

   task automatic do_reset();
      bit r, v;
      cycle(1'b1, 1'b0, r, v);
      env_clear();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit r, v;
      int nren, npop, first_pop, last_pop;
      logic [7:0] ren_vec, vld_vec;
      bit seen_addr_wrap, seen_gray_wrap;
      logic [AW-1:0] last_raddr;
      logic [AW:0]   last_gray;
      bit            had_ren;

      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      repeat (2) @(posedge clk);

      // 1: reset with a non-empty write pointer (bin 6 = Gray 5)
      for (int i = 0; i < 6; i++) write_word(16'(16'h0100 + i));
      chk("t1_wptr_gray", 32'(gray(wcnt)), 32'd5);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, r, v);
      chk("t1_mdata_rst", 32'(m_data), 32'd0);
      cycle(1'b0, 1'b0, r, v);
      chk("t1_first_ren", 32'(r), 32'd1);
      chk("t1_first_raddr", 32'(raddr), 32'd0);
      do_reset();

      // 2: streaming four words with m_ready high
      for (int i = 0; i < 4; i++) write_word(16'(16'h00A0 + i));
      ren_vec = '0; vld_vec = '0;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 1'b1, r, v);
         ren_vec[i] = r;
         vld_vec[i] = v;
      end
      chk("t2_ren_pattern",   32'(ren_vec), 32'h0F);
      chk("t2_valid_pattern", 32'(vld_vec), 32'h3C);
      chk("t2_rptr_gray",     32'(rptr_gray), 32'd6);
      chk("t2_empty",         32'(empty), 32'd1);
      do_reset();

      // 3: backpressure then drain of eight words
      for (int i = 0; i < 4; i++) write_word(16'(16'h00D0 + i));
      nren = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b0, r, v);
         nren += int'(r);
      end
      chk("t3_ren_count", 32'(nren), 32'd2);
      chk("t3_head_held", 32'(m_data), 32'h00D0);
      npop = 0; first_pop = -1; last_pop = -1;
      for (int i = 0; i < 40 && npop < 8; i++) begin
         while (wcnt < 8 && (wcnt - pops) < DEPTH) write_word(16'(16'h00D0 + wcnt));
         cycle(1'b0, 1'b1, r, v);
         if (v) begin
            if (first_pop < 0) first_pop = i;
            last_pop = i;
            npop++;
         end
      end
      chk("t3_pop_count", 32'(npop), 32'd8);
      chk("t3_no_gap",    32'(last_pop - first_pop), 32'd7);
      do_reset();

      // 4: pointer wrap over ten cumulative words
      seen_addr_wrap = 0; seen_gray_wrap = 0; had_ren = 0;
      last_raddr = '0; last_gray = '0;
      for (int i = 0; i < 80 && pops < 10; i++) begin
         if (wcnt < 10 && (wcnt - pops) < DEPTH && $urandom_range(3) != 0)
            write_word(16'($urandom));
         cycle(1'b0, $urandom_range(3) != 0, r, v);
         if (r) begin
            if (had_ren && last_raddr == 2'd3 && raddr == 2'd0) seen_addr_wrap = 1;
            last_raddr = raddr;
            had_ren = 1;
         end
         if (last_gray == 3'd4 && rptr_gray == 3'd0) seen_gray_wrap = 1;
         last_gray = rptr_gray;
      end
      cycle(1'b0, 1'b0, r, v);
      if (last_gray == 3'd4 && rptr_gray == 3'd0) seen_gray_wrap = 1;
      chk("t4_pops",      32'(pops), 32'd10);
      chk("t4_addr_wrap", 32'(seen_addr_wrap), 32'd1);
      chk("t4_gray_wrap", 32'(seen_gray_wrap), 32'd1);
      do_reset();

      // 5: reset in the cycle after a read, with a stray response afterwards
      for (int i = 0; i < 3; i++) write_word(16'(16'h0500 + i));
      cycle(1'b0, 1'b0, r, v);
      chk("t5_ren_before", 32'(r), 32'd1);
      cycle(1'b1, 1'b0, r, v);
      inj_rdv = 1'b1;
      env_clear();
      cycle(1'b0, 1'b1, r, v);
      inj_rdv = 1'b0;
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, r, v);
      chk("t5_no_stale_valid", 32'(m_valid), 32'd0);
      chk("t5_rptr_gray", 32'(rptr_gray), 32'd0);
      for (int i = 0; i < 3; i++) write_word(16'(16'h0600 + i));
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, r, v);
      chk("t5_fresh_pops", 32'(pops), 32'd3);
      do_reset();

`ifdef FIFO_RD_LEVEL_EN
      // 6: fill level; the fifth word is announced but never read
      for (int i = 0; i < 4; i++) write_word(16'(16'h0700 + i));
      wcnt++;
      exp_q.push_back(16'h0000);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, r, v);
      chk("t6_level5", 32'(rd_level), 32'd5);
      for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, r, v);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, r, v);
      chk("t6_level3", 32'(rd_level), 32'd3);
      do_reset();
`endif

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(199) == 0) begin
            do_reset();
         end else begin
            if ($urandom_range(2) != 0 && (wcnt - pops) < DEPTH) write_word(16'($urandom));
            cycle(1'b0, $urandom_range(9) < 7, r, v);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
